band_gain_stage: RTL

Parametrised multi-band gain stage for the 8-band equaliser. It sits between the band-split filter bank and the band summer. Each band has its own user gain, set by inc/dec buttons through band_sel. Gain uses a fixed-point format with rounding and saturation. Gain changes glide toward the target one LSB at a time, paced by the sample count, so buttons do not cause zipper noise. Fixed 2-cycle pipeline latency, valid-qualified data.

---
 rtl/band_gain_stage.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/band_gain_stage.sv
// Multi-band gain stage: per-band target gain set by inc/dec, gliding current gain,
// two-stage multiply / round / saturate datapath with sticky per-band clip flags.
module band_gain_stage #(
  parameter int NUM_BANDS    = 8,
  parameter int DATA_W       = 16,
  parameter int GAIN_W       = 4,
  parameter int FRAC_W       = 2,
  parameter int DEFAULT_GAIN = 4,
  parameter int RAMP_DIV     = 64,
  parameter int SEL_W        = (NUM_BANDS > 1) ? $clog2(NUM_BANDS) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  input  logic [NUM_BANDS*DATA_W-1:0]   in_data,
  input  logic [SEL_W-1:0]              band_sel,
  input  logic                          inc,
  input  logic                          dec,
  input  logic                          clr_sat,
  output logic                          out_valid,
  output logic [NUM_BANDS*DATA_W-1:0]   out_data,
  output logic [NUM_BANDS-1:0]          sat_flag,
  output logic [GAIN_W-1:0]             gain_rd,
  output logic                          ramp_busy
);

  localparam int PROD_W = DATA_W + GAIN_W + 1;
  localparam int CNT_W  = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;

  localparam logic [GAIN_W-1:0]        GAIN_MAX = {GAIN_W{1'b1}};
  localparam logic [GAIN_W-1:0]        GAIN_DEF = GAIN_W'(DEFAULT_GAIN);
  localparam logic [CNT_W-1:0]         CNT_LAST = CNT_W'(RAMP_DIV - 1);
  localparam logic signed [PROD_W-1:0] RND      = PROD_W'(2 ** (FRAC_W - 1));
  localparam logic signed [PROD_W-1:0] OUT_MAX  = {{(PROD_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [PROD_W-1:0] OUT_MIN  = {{(PROD_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  logic [GAIN_W-1:0]        target_r      [NUM_BANDS];
  logic [GAIN_W-1:0]        current_r     [NUM_BANDS];
  logic [GAIN_W-1:0]        target_next_s [NUM_BANDS];
  logic [GAIN_W-1:0]        current_next_s[NUM_BANDS];
  logic [CNT_W-1:0]         ramp_cnt_r;
  logic [CNT_W-1:0]         ramp_cnt_next_s;
  logic                     ramp_step_s;
  logic                     busy_next_s;

  logic signed [PROD_W-1:0] prod_s [NUM_BANDS];
  logic signed [PROD_W-1:0] prod_r [NUM_BANDS];
  logic                     valid1_r;
  logic signed [PROD_W-1:0] sum_s  [NUM_BANDS];
  logic signed [PROD_W-1:0] shift_s[NUM_BANDS];
  logic [DATA_W-1:0]        clip_s [NUM_BANDS];
  logic [NUM_BANDS-1:0]     sat_s;

  // Button handling: saturating per-band target update; out-of-range band_sel matches nothing.
  always_comb begin
    target_next_s = target_r;
    for (int b = 0; b < NUM_BANDS; b++) begin
      if (band_sel != SEL_W'(b)) begin
        target_next_s[b] = target_r[b];
      end else if (inc && !dec && (target_r[b] != GAIN_MAX)) begin
        target_next_s[b] = target_r[b] + GAIN_W'(1);
      end else if (dec && !inc && (target_r[b] != '0)) begin
        target_next_s[b] = target_r[b] - GAIN_W'(1);
      end else begin
        target_next_s[b] = target_r[b];
      end
    end
  end

  // Ramp pacing: one LSB step toward the old target every RAMP_DIV accepted samples.
  always_comb begin
    ramp_step_s     = in_valid && (ramp_cnt_r == CNT_LAST);
    ramp_cnt_next_s = ramp_cnt_r;
    current_next_s  = current_r;
    busy_next_s     = 1'b0;
    if (!in_valid) begin
      ramp_cnt_next_s = ramp_cnt_r;
    end else if (ramp_step_s) begin
      ramp_cnt_next_s = '0;
    end else begin
      ramp_cnt_next_s = ramp_cnt_r + CNT_W'(1);
    end
    for (int b = 0; b < NUM_BANDS; b++) begin
      if (!ramp_step_s || (current_r[b] == target_r[b])) begin
        current_next_s[b] = current_r[b];
      end else if (current_r[b] < target_r[b]) begin
        current_next_s[b] = current_r[b] + GAIN_W'(1);
      end else begin
        current_next_s[b] = current_r[b] - GAIN_W'(1);
      end
      busy_next_s = busy_next_s | (current_next_s[b] != target_next_s[b]);
    end
  end

  // Readback mux of the target code for the selected band.
  always_comb begin
    gain_rd = '0;
    for (int b = 0; b < NUM_BANDS; b++) begin
      gain_rd = (band_sel == SEL_W'(b)) ? target_r[b] : gain_rd;
    end
  end

  // Gain state, ramp counter and busy flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int b = 0; b < NUM_BANDS; b++) begin
        target_r[b]  <= GAIN_DEF;
        current_r[b] <= GAIN_DEF;
      end
      ramp_cnt_r <= '0;
      ramp_busy  <= 1'b0;
    end else begin
      target_r   <= target_next_s;
      current_r  <= current_next_s;
      ramp_cnt_r <= ramp_cnt_next_s;
      ramp_busy  <= busy_next_s;
    end
  end

  // Stage 1 product: the gain is zero-extended so it multiplies as a non-negative value.
  always_comb begin
    for (int b = 0; b < NUM_BANDS; b++) begin
      prod_s[b] = PROD_W'($signed(in_data[b*DATA_W +: DATA_W])) *
                  PROD_W'($signed({1'b0, current_r[b]}));
    end
  end

  // Stage 1 register; products are only refreshed for accepted samples.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid1_r <= 1'b0;
      for (int b = 0; b < NUM_BANDS; b++) begin
        prod_r[b] <= '0;
      end
    end else begin
      valid1_r <= in_valid;
      if (in_valid) begin
        prod_r <= prod_s;
      end else begin
        prod_r <= prod_r;
      end
    end
  end

  // Stage 2 arithmetic: round half toward +inf, then clamp to the sample range.
  always_comb begin
    sat_s = '0;
    for (int b = 0; b < NUM_BANDS; b++) begin
      sum_s[b]   = prod_r[b] + RND;
      shift_s[b] = sum_s[b] >>> FRAC_W;
      if (shift_s[b] > OUT_MAX) begin
        clip_s[b] = OUT_MAX[DATA_W-1:0];
        sat_s[b]  = 1'b1;
      end else if (shift_s[b] < OUT_MIN) begin
        clip_s[b] = OUT_MIN[DATA_W-1:0];
        sat_s[b]  = 1'b1;
      end else begin
        clip_s[b] = shift_s[b][DATA_W-1:0];
        sat_s[b]  = 1'b0;
      end
    end
  end

  // Output register: data holds through bubbles, saturation set wins over clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      sat_flag  <= '0;
    end else begin
      out_valid <= valid1_r;
      if (valid1_r) begin
        for (int b = 0; b < NUM_BANDS; b++) begin
          out_data[b*DATA_W +: DATA_W] <= clip_s[b];
        end
        sat_flag <= (sat_flag & ~{NUM_BANDS{clr_sat}}) | sat_s;
      end else begin
        out_data <= out_data;
        sat_flag <= sat_flag & ~{NUM_BANDS{clr_sat}};
      end
    end
  end

endmodule
